uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, rx_data is new.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port parity_err, output, 1 bit: one-cycle pulse, parity mismatch (tied 0 when parity is compiled out).

Function
REQ-010 SHALL pass uart_rxd through a 2-flop synchronizer preset to 1; all decisions use the synchronized value.
REQ-011 SHALL generate a 16x-oversample tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (54 at the defaults); the tick counter restarts at 0 on each start-bit falling edge.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE: on a synchronized 1->0 edge SHALL clear the tick phase and go to START.
REQ-014 START: at tick phase 8, a low line SHALL go to DATA; a high line (glitch) SHALL return to IDLE with no output pulse.
REQ-015 DATA: SHALL sample 8 bits LSB first at phase 8 of each 16-tick bit into a shift register.
REQ-016 PARITY (present only with the macro): SHALL sample one bit and compare it with even parity over the 8 data bits.
REQ-017 STOP: at phase 8, a high line SHALL load rx_data and pulse rx_valid on the next clock, then go to IDLE.
REQ-018 STOP: a low line SHALL pulse frame_err, leave rx_data unchanged, raise no rx_valid, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL stay until the line has been high for 16 consecutive ticks (break/garbage suppression), then go to IDLE.
REQ-020 On a parity mismatch with a good stop bit, SHALL pulse parity_err in the same cycle as rx_valid; rx_data still updates.
REQ-021 rx_valid, frame_err and parity_err SHALL each be high for exactly one clock per frame and never together except as in REQ-020.
REQ-022 A new start edge arriving in the same cycle as rx_valid SHALL be accepted (back-to-back frames, no lost bytes).
REQ-023 rx_data SHALL be held stable between rx_valid pulses.

Reset
REQ-024 While rst is high: state=IDLE, synchronizer=1, tick and bit counters=0, rx_data=8'h00, and all pulse outputs=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no output pulse; after release a falling edge is needed to start a new frame.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, the frame SHALL be 8E1 and the PARITY state and parity_err logic SHALL be present.
REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, DATA SHALL go directly to STOP, and parity_err SHALL be constant 0.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, SAMPLE_PHASE=8, and a constant function computing DIV.
REQ-029 SHALL instantiate sub-module uart_baud_tick (parameter DIV; inputs clk, rst, restart; output tick) for the oversample counter.

Verification (CLK_FREQ=100e6, BAUD=115200, bit = 864 clocks)
REQ-030 Send 0x77 ('w') as 8N1 -> exactly one rx_valid, rx_data=0x77, arriving within 9.5 bit times of the start edge.
REQ-031 Send 0x57 ('W') then 0x61 ('a') back-to-back with no idle gap -> two rx_valid pulses, data 0x57 then 0x61.
REQ-032 Hold uart_rxd low for 300 clocks then high -> no output pulse; state is back in IDLE.
REQ-033 Send 0x64 with the stop bit low, then hold the line low for 2 frames -> one frame_err, no rx_valid, rx_data unchanged; a following 0x6A is received correctly.
REQ-034 With UART_RX_PARITY_EN, send 0x6E with a parity bit of 0 (correct value is 1) -> rx_valid and parity_err in the same cycle, rx_data=0x6E.
REQ-035 Assert rst for 1 clock after data bit 4 of a frame -> no pulse for that frame; the next full frame 0x4E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the uart_rx receiver: FSM state
//            encoding, oversampling constants and the baud divider function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Ticks per serial bit and the tick at which a bit is sampled (mid-bit)
    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_PHASE = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest: round(clk/(baud*16))
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Free-running oversample tick generator. Emits a one-clock tick
//            every DIV clocks; restart realigns the count to zero so the
//            first tick lands DIV clocks after a detected start edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Divide the system clock down to the oversample rate
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampling UART receiver, 8 data bits LSB first, 1 stop
//            bit. Frame errors suppress output until the line has been idle
//            for a full bit time.
// Config   : define UART_RX_PARITY_EN for 8E1 framing with parity checking;
//            without it the frame is 8N1 and parity_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    // The sampling tick is the one that advances the phase to SAMPLE_PHASE
    localparam logic [3:0] PH_SAMPLE = 4'(SAMPLE_PHASE - 1);
    localparam logic [3:0] PH_LAST   = 4'(OVERSAMPLE - 1);

    logic        sync_1;
    logic        line;
    logic        line_q;
    logic        fall;
    logic        restart;
    logic        tick;
    logic        sample;

    uart_state_t state;
    logic [3:0]  phase;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    assign fall    = line_q & ~line;
    assign restart = (state == S_IDLE) && fall;
    assign sample  = tick && (phase == PH_SAMPLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchronizer plus one delay stage for falling-edge detection;
    // all preset high so reset never looks like a start edge on an idle line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            line   <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync_1 <= uart_rxd;
            line   <= sync_1;
            line_q <= line;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`endif

    // Frame FSM with registered data and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= 4'd0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick) begin
                phase <= phase + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        phase   <= 4'd0;
                        bit_cnt <= 3'd0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    // A line that has gone high again by mid-bit was a glitch
                    if (sample) begin
                        state <= line ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shreg   <= {line, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data
                    if (sample) begin
                        par_bad <= line ^ (^shreg);
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (sample) begin
                        if (line) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            phase     <= 4'd0;
                            state     <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Phase counts consecutive high ticks; any low tick restarts it
                    if (tick) begin
                        if (!line) begin
                            phase <= 4'd0;
                        end else if (phase == PH_LAST) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at 100 MHz / 115200 baud.
//            Frames are driven bit by bit; each expected output pulse is
//            queued when its frame is driven and compared when it appears.
// Config   : honours UART_RX_PARITY_EN (adds the parity bit to frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 115200;
    localparam int BIT_CLKS = 864;          // 54 clocks/tick * 16 ticks
    localparam int FRAME10  = 10 * BIT_CLKS;
    // rx_valid follows the mid-stop sample: 9.5 bits plus a few clocks of
    // synchronizer / edge-detect / tick alignment
    localparam int LAT_MIN  = 9 * BIT_CLKS;
    localparam int LAT_MAX  = (19 * BIT_CLKS) / 2 + 8;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b101;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         start;
        bit         chk_lat;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       bad_par;
        logic [2:0] kind;
        bit         chk_lat;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[$];
    logic [7:0] last_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`else
        if (bad_par) $display("note: parity bit not part of 8N1 frame");
`endif
        send_bit(stop_bit);
    endtask

    // Reference model: expected pulse kind and the rx_data it must show
    task automatic expect_frame(input logic [7:0] d, input logic [2:0] kind, input bit chk_lat);
        exp_t e;
        e.kind    = kind;
        e.start   = cyc;
        e.chk_lat = chk_lat;
        if (kind[2]) begin
            last_data = d;
        end
        e.data = last_data;
        sb.push_back(e);
    endtask

    // Every status pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err || parity_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({rx_valid, frame_err, parity_err}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", 32'({rx_valid, frame_err, parity_err}), 32'(mon_e.kind));
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                if (mon_e.chk_lat) begin
                    check("latency_in_window",
                          32'((cyc - mon_e.start >= LAT_MIN) && (cyc - mon_e.start <= LAT_MAX)),
                          32'd1);
                end
            end
        end
    end

    initial begin
        vecs.push_back('{8'h77, 1'b1, 1'b0, K_VALID, 1'b1});
        vecs.push_back('{8'h57, 1'b1, 1'b0, K_VALID, 1'b0});
        vecs.push_back('{8'h61, 1'b1, 1'b0, K_VALID, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h6E, 1'b1, 1'b1, K_PERR,  1'b0});
`endif

        // Reset state
        wait_clks(5);
        check("reset_rx_data",    32'(rx_data),    32'h00);
        check("reset_rx_valid",   32'(rx_valid),   32'd0);
        check("reset_frame_err",  32'(frame_err),  32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        wait_clks(20);

        // Table frames, driven back-to-back with no idle gap
        for (int i = 0; i < vecs.size(); i++) begin
            expect_frame(vecs[i].data, vecs[i].kind, vecs[i].chk_lat);
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].bad_par);
        end
        uart_rxd = 1'b1;
        wait_clks(BIT_CLKS);

        // Short low glitch: rejected at mid-start-bit, no pulse
        uart_rxd = 1'b0;
        wait_clks(300);
        uart_rxd = 1'b1;
        wait_clks(600);
        check("glitch_state_idle", 32'(dut.state), 32'(S_IDLE));

        // Bad stop bit, then a two-frame break, then a good frame
        expect_frame(8'h64, K_FERR, 1'b0);
        send_frame(8'h64, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        wait_clks(2 * FRAME10);
        uart_rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        expect_frame(8'h6A, K_VALID, 1'b0);
        send_frame(8'h6A, 1'b1, 1'b0);

        // Reset one clock during data bit 5 of 0xE5 (bits 5..7 and stop high)
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(8'hE5 >> i));
        uart_rxd = 1'b1;
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        last_data = 8'h00;
        wait_clks(1);
        rst = 1'b0;
        wait_clks(BIT_CLKS);
        expect_frame(8'h4E, K_VALID, 1'b0);
        send_frame(8'h4E, 1'b1, 1'b0);
        wait_clks(BIT_CLKS / 2);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
